step_shaper: RTL and testbench
==============================

Name: step_shaper

Overview:
- Sits directly downstream of the step/dir generator and drives the external stepper-driver pins.
- Converts generator step events (level pulse or double-edge toggle) into driver-legal waveforms: programmable step pulse width, minimum low time, dir setup time before the active edge, and dir hold time after it.
- Buffers events that arrive faster than the timing allows in a small direction-bit FIFO, so no step is lost and step order and direction are preserved.

Parameters:
- TIME_BITS, 8, width of all timing config inputs (in clk cycles).
- FIFO_DEPTH, 16, pending-step FIFO depth (power of 2, >=2).
- CNT_BITS, $clog2(FIFO_DEPTH+1), width of the pending output.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- step_in  input  1  step from generator.
- dir_in  input  1  dir from generator; valid in the cycle step_in changes.
- dedge_in  input  1  1 = a step is any toggle of step_in; 0 = a step is a rising edge of step_in.
- enable  input  1  1 = launch queued steps; 0 = hold them.
- pulse_width  input  TIME_BITS  step_out high time in non-dedge mode; 0 is treated as 1.
- min_low  input  TIME_BITS  gap after a pulse (or after a toggle in dedge mode); 0 is treated as 1.
- dir_setup  input  TIME_BITS  cycles from a dir_out change to the next active edge.
- dir_hold  input  TIME_BITS  cycles after an active edge before dir_out may change.
- clear_ovf  input  1  synchronous clear of overflow.
- step_out  output  1  shaped step to driver.
- dir_out  output  1  dir to driver.
- pending  output  CNT_BITS  FIFO occupancy.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n low, async): step_out=0, dir_out=0, pending=0, overflow=0, FSM=IDLE, all timers 0, FIFO empty, step_d=0, mode latch=0.
- Event detection:
  - step_d is step_in registered.
  - An event occurs when step_in!=step_d and (dedge_in or step_in==1).
  - On an event, dir_in is pushed into the FIFO at the same edge.
- FIFO full handling:
  - Event while full with no pop that cycle: event dropped, overflow<=1.
  - Push and pop in the same cycle while full: push is accepted.
- clear_ovf clears overflow; an overflow in the same cycle wins.
- Mode latch: dedge_in is latched into the mode register only while in IDLE with the FIFO empty. Changes at other times take effect at the next such point.
- hold_t timer: loaded with dir_hold at every active edge, then decrements to 0.
- FSM states: IDLE, SETUP, HIGH, LOW.
- IDLE, when enable=1 and FIFO non-empty, looks at head bit h:
  - If h==dir_out: perform the active edge on the next edge.
  - Else, if hold_t==0: dir_out<=h, timer<=dir_setup, go to SETUP. If dir_setup==0, go straight to the active edge on the following cycle.
  - Else: wait in IDLE.
- SETUP: count the timer down to 0, then perform the active edge.
- Active edge:
  - Pop the FIFO and load hold_t.
  - Non-dedge mode: step_out<=1, timer<=max(pulse_width,1), go to HIGH.
  - Dedge mode: step_out<=~step_out, timer<=max(min_low,1), go to LOW.
- HIGH: step_out held 1 for exactly max(pulse_width,1) cycles, then step_out<=0, timer<=max(min_low,1), go to LOW.
- LOW: step_out held for max(min_low,1) cycles, then go to IDLE. IDLE may launch in its first cycle.
- Latency: with FIFO empty, FSM in IDLE, enable=1 and no dir change, step_out changes at the clk edge after the edge that samples the step_in change (1 cycle).
- enable=0: a pulse already in progress completes (HIGH/LOW/SETUP finish); new launches stop; the FIFO keeps accepting events.
- dir_out never changes in the HIGH state or while hold_t!=0.
- pending reflects the FIFO count after the edge, and is consistent with push/pop in the same cycle.
- Timer widths are TIME_BITS with no wrap; all compares are against 0.

Test Plan:
- Non-dedge timing: pulse_width=4, min_low=3, dir_setup=0, dir_hold=0, dir_in=0; single rising step_in sampled at edge 10 -> step_out high after edges 11..14, low at 15; dir_out stays 0; pending 1 then 0.
- Back-to-back burst, same setup: rising step_in at edges 10 and 12 -> pulses start at edges 11 and 18; pending peaks at 1; no overflow.
- Dir change: dir_setup=5, dir_hold=2, pulse_width=2, min_low=1; events dir=0 at edge 10, dir=1 at edge 11 -> step_out rises at 11; dir_out goes 1 at edge 15 (after HIGH/LOW, hold expired) and step_out rises at edge 21.
- Overflow: enable=0, 17 rising events -> pending=16, overflow=1; then enable=1 -> exactly 16 pulses, pending=0; clear_ovf -> overflow=0.
- Dedge: dedge_in=1 while idle, min_low=2; step_in toggles at edges 10 and 11 -> step_out toggles at 11 and 13; final level 0.
- Reset mid-pulse: rst_n low during HIGH with pending=3 -> step_out=0, dir_out=0, pending=0, overflow=0 immediately (async); after release, no pulse until a new event.

Source files
------------

// File: rtl/step_shaper.sv
`default_nettype none
// ============================================================================
// Module : step_shaper
// Turns generator step events into driver-legal step/dir pin waveforms,
// queuing the direction of early events in a small FIFO.
// Rev    : 1.0
// ============================================================================
module step_shaper #(
    parameter int TIME_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_BITS   = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_in,
    input  logic                 dir_in,
    input  logic                 dedge_in,
    input  logic                 enable,
    input  logic [TIME_BITS-1:0] pulse_width,
    input  logic [TIME_BITS-1:0] min_low,
    input  logic [TIME_BITS-1:0] dir_setup,
    input  logic [TIME_BITS-1:0] dir_hold,
    input  logic                 clear_ovf,
    output logic                 step_out,
    output logic                 dir_out,
    output logic [CNT_BITS-1:0]  pending,
    output logic                 overflow
);
    localparam int                   PTR_BITS = $clog2(FIFO_DEPTH);
    localparam logic [TIME_BITS-1:0] T_ONE    = TIME_BITS'(1);
    localparam logic [PTR_BITS-1:0]  PTR_ONE  = PTR_BITS'(1);
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]  CNT_FULL = CNT_BITS'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [TIME_BITS-1:0]  timer_q, timer_d;
    logic [TIME_BITS-1:0]  hold_q, hold_d;
    logic                  step_out_q, step_out_d;
    logic                  dir_out_q, dir_out_d;
    logic                  mode_q, mode_d;
    logic                  ovf_q, ovf_d;
    logic                  step_in_q;
    logic [FIFO_DEPTH-1:0] fifo_q;
    logic [PTR_BITS-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_BITS-1:0]   count_q;

    logic                  evt, push, pop, drop, launch;
    logic                  empty, full, head, ready;
    logic [TIME_BITS-1:0]  pw_m1, ml_m1;

    assign evt   = (step_in != step_in_q) && (dedge_in || step_in);
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign head  = fifo_q[rd_ptr_q];
    assign ready = enable && !empty;
    assign pop   = launch;
    assign push  = evt && (!full || pop);
    assign drop  = evt && full && !pop;

    // HIGH/LOW timers hold "cycles remaining minus one" so expiry is a compare to 0.
    assign pw_m1 = (pulse_width == '0) ? '0 : pulse_width - T_ONE;
    assign ml_m1 = (min_low == '0) ? '0 : min_low - T_ONE;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        step_out_d = step_out_q;
        dir_out_d  = dir_out_q;
        hold_d     = (hold_q != '0) ? hold_q - T_ONE : '0;
        launch     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ready) begin
                    if (head == dir_out_q) begin
                        launch = 1'b1;
                    end else if (hold_q == '0) begin
                        dir_out_d = head;
                        timer_d   = dir_setup;
                        state_d   = SETUP;
                    end
                end
            end
            SETUP: begin
                if (timer_q == '0) launch = 1'b1;
                else               timer_d = timer_q - T_ONE;
            end
            HIGH: begin
                if (timer_q == '0) begin
                    step_out_d = 1'b0;
                    timer_d    = ml_m1;
                    state_d    = LOW;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            LOW: begin
                // Same-direction steps chain straight on; a dir change goes via IDLE.
                if (timer_q == '0) begin
                    if (ready && (head == dir_out_q)) launch = 1'b1;
                    else                               state_d = IDLE;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            hold_d = dir_hold;
            if (mode_q) begin
                step_out_d = ~step_out_q;
                timer_d    = ml_m1;
                state_d    = LOW;
            end else begin
                step_out_d = 1'b1;
                timer_d    = pw_m1;
                state_d    = HIGH;
            end
        end
    end

    assign mode_d = ((state_q == IDLE) && empty) ? dedge_in : mode_q;
    assign ovf_d  = drop ? 1'b1 : (clear_ovf ? 1'b0 : ovf_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            hold_q     <= '0;
            step_out_q <= 1'b0;
            dir_out_q  <= 1'b0;
            mode_q     <= 1'b0;
            ovf_q      <= 1'b0;
            step_in_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
            step_out_q <= step_out_d;
            dir_out_q  <= dir_out_d;
            mode_q     <= mode_d;
            ovf_q      <= ovf_d;
            step_in_q  <= step_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= dir_in;
                wr_ptr_q         <= wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_q <= count_q + CNT_ONE;
            else if (pop && !push) count_q <= count_q - CNT_ONE;
        end
    end

    assign step_out = step_out_q;
    assign dir_out  = dir_out_q;
    assign pending  = count_q;
    assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_step_shaper.sv
`default_nettype none
// ============================================================================
// Module : tb_step_shaper
// Directed bench for step_shaper: time-based reference model plus literal checks.
// Rev    : 1.0
// ============================================================================
module tb_step_shaper;
    localparam int TB    = 8;
    localparam int DEPTH = 16;
    localparam int CB    = 5;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          step_in = 1'b0, dir_in = 1'b0, dedge_in = 1'b0;
    logic          enable = 1'b0, clear_ovf = 1'b0;
    logic [TB-1:0] pulse_width = '0, min_low = '0, dir_setup = '0, dir_hold = '0;
    logic          step_out, dir_out, overflow;
    logic [CB-1:0] pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    step_shaper #(.TIME_BITS(TB), .FIFO_DEPTH(DEPTH), .CNT_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .step_in(step_in), .dir_in(dir_in),
        .dedge_in(dedge_in), .enable(enable), .pulse_width(pulse_width),
        .min_low(min_low), .dir_setup(dir_setup), .dir_hold(dir_hold),
        .clear_ovf(clear_ovf), .step_out(step_out), .dir_out(dir_out),
        .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Reference model: schedules edges from absolute edge times.
    bit mq[$];
    bit m_step, m_dir, m_ovf, m_mode, m_prev, m_setup;
    int m_tfree, m_tdirfree, m_tcommit, m_tfall;

    task automatic model_reset();
        cyc = 0; mq.delete();
        m_step = 0; m_dir = 0; m_ovf = 0; m_mode = 0; m_prev = 0; m_setup = 0;
        m_tfree = 0; m_tdirfree = 0; m_tcommit = 0; m_tfall = -1;
    endtask

    task automatic model_step();
        bit ev, idle_pre, was_empty, launch, is_full;
        int pw, ml, dh;
        pw = (pulse_width == 0) ? 1 : int'(pulse_width);
        ml = (min_low == 0) ? 1 : int'(min_low);
        dh = int'(dir_hold);
        ev        = (step_in != m_prev) && (dedge_in || step_in);
        idle_pre  = !m_setup && (cyc > m_tfree);
        was_empty = (mq.size() == 0);
        launch    = 0;
        if (cyc == m_tfall) m_step = 0;
        if (m_setup) begin
            launch = (cyc == m_tcommit);
        end else if (cyc >= m_tfree && enable && mq.size() > 0) begin
            if (mq[0] == m_dir) begin
                launch = 1;
            end else if (cyc >= m_tdirfree) begin
                m_dir = mq[0];
                m_setup = 1;
                m_tcommit = cyc + int'(dir_setup) + 1;
            end
        end
        if (launch) begin
            void'(mq.pop_front());
            m_setup = 0;
            if (m_mode) begin
                m_step  = !m_step;
                m_tfree = cyc + ml;
            end else begin
                m_step  = 1;
                m_tfall = cyc + pw;
                m_tfree = cyc + pw + ml;
            end
            m_tdirfree = (m_tfree + 1 > cyc + dh + 1) ? m_tfree + 1 : cyc + dh + 1;
        end
        is_full = (mq.size() >= DEPTH);
        if (ev && !is_full) mq.push_back(dir_in);
        if (ev && is_full)  m_ovf = 1;
        else if (clear_ovf) m_ovf = 0;
        if (idle_pre && was_empty) m_mode = dedge_in;
        m_prev = step_in;
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else begin
            cyc++;
            model_step();
        end
        #2;
        chk("model_step_out", step_out, m_step);
        chk("model_dir_out", dir_out, m_dir);
        chk("model_pending", pending, mq.size());
        chk("model_overflow", overflow, m_ovf);
    end

    task automatic to_edge(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic cfg(input int pw, input int ml, input int ds, input int dh, input bit de);
        pulse_width = TB'(pw); min_low = TB'(ml); dir_setup = TB'(ds); dir_hold = TB'(dh);
        dedge_in = de; enable = 1'b1; step_in = 1'b0; dir_in = 1'b0; clear_ovf = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // {dir_setup, dir_hold, edge where dir_out rises, edge where the second pulse starts}
    int dir_tab[3][4] = '{'{5, 2, 15, 21}, '{0, 8, 20, 21}, '{3, 0, 15, 19}};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        logic prev;

        // Single pulse, non-dedge
        cfg(4, 3, 0, 0, 0);
        @(negedge clk);
        chk("reset_step_out", step_out, 0);
        chk("reset_dir_out", dir_out, 0);
        chk("reset_pending", pending, 0);
        chk("reset_overflow", overflow, 0);
        do_reset();
        to_edge(9);  step_in = 1'b1;
        to_edge(10); chk("t1_pending_push", pending, 1); chk("t1_latency_low", step_out, 0);
        step_in = 1'b0;
        to_edge(11); chk("t1_rise", step_out, 1); chk("t1_pending_pop", pending, 0);
        to_edge(14); chk("t1_still_high", step_out, 1);
        to_edge(15); chk("t1_fall", step_out, 0); chk("t1_dir", dir_out, 0);
        to_edge(20);

        // Back-to-back burst
        cfg(4, 3, 0, 0, 0);
        do_reset();
        to_edge(9);  step_in = 1'b1;
        to_edge(10); step_in = 1'b0;
        to_edge(11); step_in = 1'b1; chk("t2_first_rise", step_out, 1);
        to_edge(12); step_in = 1'b0; chk("t2_pending_peak", pending, 1);
        to_edge(17); chk("t2_min_low", step_out, 0);
        to_edge(18); chk("t2_second_rise", step_out, 1); chk("t2_pending_drained", pending, 0);
        to_edge(25); chk("t2_no_overflow", overflow, 0);

        // Direction change with setup/hold
        foreach (dir_tab[i]) begin
            cfg(2, 1, dir_tab[i][0], dir_tab[i][1], 0);
            do_reset();
            to_edge(9);  step_in = 1'b1; dir_in = 1'b0;
            to_edge(10); step_in = 1'b0;
            to_edge(11); step_in = 1'b1; dir_in = 1'b1;
            to_edge(12); step_in = 1'b0; chk("t3_first_high", step_out, 1);
            to_edge(dir_tab[i][2] - 1); chk("t3_dir_before", dir_out, 0);
            to_edge(dir_tab[i][2]);     chk("t3_dir_after", dir_out, 1);
            to_edge(dir_tab[i][3] - 1); chk("t3_step_before", step_out, 0);
            to_edge(dir_tab[i][3]);     chk("t3_step_after", step_out, 1);
            to_edge(dir_tab[i][3] + 5);
        end

        // Overflow, clear priority, push+pop while full
        cfg(1, 1, 0, 0, 0);
        enable = 1'b0;
        do_reset();
        repeat (17) begin
            step_in = 1'b1; @(negedge clk);
            step_in = 1'b0; @(negedge clk);
        end
        chk("t4_pending_full", pending, 16);
        chk("t4_overflow_set", overflow, 1);
        step_in = 1'b1; clear_ovf = 1'b1; @(negedge clk);
        chk("t4_ovf_beats_clear", overflow, 1);
        step_in = 1'b0; @(negedge clk);
        chk("t4_ovf_cleared", overflow, 0);
        clear_ovf = 1'b0;
        step_in = 1'b1; enable = 1'b1; @(negedge clk);
        step_in = 1'b0;
        chk("t4_full_push_pop", pending, 16);
        chk("t4_no_ovf_on_pop", overflow, 0);
        pulses = (step_out === 1'b1) ? 1 : 0;
        prev = step_out;
        repeat (60) begin
            @(negedge clk);
            if (step_out === 1'b1 && prev !== 1'b1) pulses++;
            prev = step_out;
        end
        chk("t4_pulse_count", pulses, 17);
        chk("t4_pending_empty", pending, 0);

        // Double-edge mode
        cfg(4, 2, 0, 0, 1);
        do_reset();
        to_edge(9);  step_in = 1'b1;
        to_edge(10); step_in = 1'b0;
        to_edge(11); chk("t5_toggle1", step_out, 1);
        to_edge(12); chk("t5_hold", step_out, 1);
        to_edge(13); chk("t5_toggle2", step_out, 0);
        to_edge(20); chk("t5_final", step_out, 0); chk("t5_pending", pending, 0);

        // Asynchronous reset during HIGH
        cfg(10, 1, 0, 0, 0);
        do_reset();
        for (int e = 2; e <= 9; e++) begin
            to_edge(e);
            step_in = (e % 2 == 0);
            dir_in  = 1'b1;
        end
        chk("t6_pending_pre", pending, 3);
        chk("t6_high_pre", step_out, 1);
        chk("t6_dir_pre", dir_out, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_step", step_out, 0);
        chk("t6_async_dir", dir_out, 0);
        chk("t6_async_pending", pending, 0);
        chk("t6_async_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_pulse_after", step_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
